// File: rtl/stft_power_framer_if.sv
// Stream bundle between the stereo STFT stage, the power framer and its consumer.
// The s_axis_* group carries complex bins in; the m_axis_* group carries tagged power out.
interface stft_power_framer_if #(
    parameter int BIN_IDX_W = 12
);
    logic [63:0]          s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic                 s_axis_tlast;
    logic [31:0]          m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic [BIN_IDX_W+1:0] m_axis_tuser;

    // slave: the framer's view (consumes bins, produces power)
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    // master: the surrounding environment's view
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/stft_power_framer.sv
// Per-bin power (re^2 + im^2, shifted and saturated to 32 bits) of an interleaved L/R STFT stream,
// re-framed per channel and tagged with {stream_end, channel, bin}; flags tlast off a frame boundary.
module stft_power_framer #(
    parameter int NUM_BINS    = 2048,
    parameter int BIN_IDX_W   = 12,
    parameter int POWER_SHIFT = 30
) (
    input  logic                clk,
    input  logic                reset,
    stft_power_framer_if.slave  axis,
    output logic                frame_err
);

    logic                 w_en;
    logic                 w_acc;
    logic                 w_frame_last;
    logic                 w_aligned_end;
    logic                 w_misaligned;

    logic [BIN_IDX_W-1:0] r_bin_cnt;
    logic                 r_channel;
    logic                 r_frame_err;

    logic                 r_s1_valid;
    logic signed [31:0]   r_s1_re;
    logic signed [31:0]   r_s1_im;
    logic [BIN_IDX_W:0]   r_s1_tag;
    logic                 r_s1_last;
    logic                 r_s1_end;

    logic                 r_s2_valid;
    logic [63:0]          r_s2_re2;
    logic [63:0]          r_s2_im2;
    logic [BIN_IDX_W:0]   r_s2_tag;
    logic                 r_s2_last;
    logic                 r_s2_end;

    logic                 r_out_valid;
    logic [31:0]          r_out_data;
    logic                 r_out_last;
    logic [BIN_IDX_W+1:0] r_out_user;

    logic signed [63:0]   w_re_ext;
    logic signed [63:0]   w_im_ext;
    logic [63:0]          w_sum;
    logic [63:0]          w_p;
    logic [31:0]          w_pwr;

    // All three stages advance together whenever the output register can move.
    assign w_en               = ~r_out_valid | axis.m_axis_tready;
    assign w_acc              = axis.s_axis_tvalid & w_en;
    assign axis.s_axis_tready = w_en;

    assign w_frame_last  = (r_bin_cnt == BIN_IDX_W'(NUM_BINS - 1));
    assign w_aligned_end = r_channel & w_frame_last;
    assign w_misaligned  = axis.s_axis_tlast & ~w_aligned_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin_cnt   <= '0;
            r_channel   <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (w_acc) begin
            if (w_misaligned) begin
                r_bin_cnt   <= '0;
                r_channel   <= 1'b0;
                r_frame_err <= 1'b1;
            end else if (w_frame_last) begin
                r_bin_cnt <= '0;
                r_channel <= ~r_channel;
            end else begin
                r_bin_cnt <= r_bin_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_re    <= '0;
            r_s1_im    <= '0;
            r_s1_tag   <= '0;
            r_s1_last  <= 1'b0;
            r_s1_end   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= w_acc;
            r_s1_re    <= axis.s_axis_tdata[31:0];
            r_s1_im    <= axis.s_axis_tdata[63:32];
            r_s1_tag   <= {r_channel, r_bin_cnt};
            // a misaligned tlast still closes the frame so downstream sees a clean end
            r_s1_last  <= w_frame_last | w_misaligned;
            r_s1_end   <= (axis.s_axis_tlast & w_aligned_end) | w_misaligned;
        end
    end

    assign w_re_ext = {{32{r_s1_re[31]}}, r_s1_re};
    assign w_im_ext = {{32{r_s1_im[31]}}, r_s1_im};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_re2   <= '0;
            r_s2_im2   <= '0;
            r_s2_tag   <= '0;
            r_s2_last  <= 1'b0;
            r_s2_end   <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_re2   <= $unsigned(w_re_ext * w_re_ext);
            r_s2_im2   <= $unsigned(w_im_ext * w_im_ext);
            r_s2_tag   <= r_s1_tag;
            r_s2_last  <= r_s1_last;
            r_s2_end   <= r_s1_end;
        end
    end

    // Each square is at most 2^62, so the sum never exceeds 2^63.
    assign w_sum = r_s2_re2 + r_s2_im2;
    assign w_p   = w_sum >> POWER_SHIFT;
    assign w_pwr = (|w_p[63:32]) ? 32'hFFFF_FFFF : w_p[31:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_user  <= '0;
        end else if (w_en) begin
            r_out_valid <= r_s2_valid;
            r_out_data  <= w_pwr;
            r_out_last  <= r_s2_last;
            r_out_user  <= {r_s2_end, r_s2_tag};
        end
    end

    assign axis.m_axis_tvalid = r_out_valid;
    assign axis.m_axis_tdata  = r_out_data;
    assign axis.m_axis_tlast  = r_out_last;
    assign axis.m_axis_tuser  = r_out_user;
    assign frame_err          = r_frame_err;

endmodule

// File: tb/tb_stft_power_framer.sv
// Bench for stft_power_framer: two instances (shift 0 and shift 30, NUM_BINS=4) share one stimulus
// and are checked every cycle against a stream-position reference model, plus literal spot checks.
module tb_stft_power_framer;
    localparam int N  = 4;
    localparam int BW = 12;
    localparam int UW = BW + 2;

    typedef struct packed {
        logic [31:0]   d0;
        logic [31:0]   d1;
        logic          l;
        logic [UW-1:0] u;
    } exp_t;

    typedef struct packed {
        logic [31:0]   d;
        logic          l;
        logic [UW-1:0] u;
    } obs_t;

    logic clk;
    logic reset;
    logic [63:0] d_tdata;
    logic d_tvalid, d_tlast, d_mready;
    logic ferr [2];
    logic [31:0] o_d [2];
    logic o_v [2];
    logic o_l [2];
    logic o_sr [2];
    logic [UW-1:0] o_u [2];

    int n_chk = 0;
    int n_fail = 0;
    int stall_pct = 0;

    exp_t expq[$];
    obs_t lg0[$];
    obs_t lg1[$];
    int rd [2];
    int pos;
    logic merr;
    logic was_stall [2];
    obs_t held [2];

    stft_power_framer_if #(.BIN_IDX_W(BW)) if0 ();
    stft_power_framer_if #(.BIN_IDX_W(BW)) if1 ();

    stft_power_framer #(.NUM_BINS(N), .BIN_IDX_W(BW), .POWER_SHIFT(0)) u0 (
        .clk(clk), .reset(reset), .axis(if0), .frame_err(ferr[0]));
    stft_power_framer #(.NUM_BINS(N), .BIN_IDX_W(BW), .POWER_SHIFT(30)) u30 (
        .clk(clk), .reset(reset), .axis(if1), .frame_err(ferr[1]));

    assign if0.s_axis_tdata  = d_tdata;
    assign if0.s_axis_tvalid = d_tvalid;
    assign if0.s_axis_tlast  = d_tlast;
    assign if0.m_axis_tready = d_mready;
    assign if1.s_axis_tdata  = d_tdata;
    assign if1.s_axis_tvalid = d_tvalid;
    assign if1.s_axis_tlast  = d_tlast;
    assign if1.m_axis_tready = d_mready;

    assign o_d[0] = if0.m_axis_tdata;  assign o_d[1] = if1.m_axis_tdata;
    assign o_v[0] = if0.m_axis_tvalid; assign o_v[1] = if1.m_axis_tvalid;
    assign o_l[0] = if0.m_axis_tlast;  assign o_l[1] = if1.m_axis_tlast;
    assign o_u[0] = if0.m_axis_tuser;  assign o_u[1] = if1.m_axis_tuser;
    assign o_sr[0] = if0.s_axis_tready; assign o_sr[1] = if1.s_axis_tready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference power: plain 64-bit arithmetic on the signed parts.
    function automatic logic [31:0] pwr(input logic [63:0] w, input int sh);
        logic signed [31:0] re;
        logic signed [31:0] im;
        longint r2, i2;
        logic [63:0] s, p;
        re = w[31:0];
        im = w[63:32];
        r2 = longint'(re) * longint'(re);
        i2 = longint'(im) * longint'(im);
        s  = 64'(r2) + 64'(i2);
        p  = s >> sh;
        return (p > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
    endfunction

    // Reference model and comparator: stream position decides channel/bin/tags.
    always @(negedge clk) begin
        exp_t e;
        obs_t a;
        int ch, bin;
        if (reset) begin
            expq.delete();
            rd[0] = 0; rd[1] = 0;
            pos = 0; merr = 1'b0;
            was_stall[0] = 1'b0; was_stall[1] = 1'b0;
        end else begin
            chk("tready_match", 64'(o_sr[1]), 64'(o_sr[0]));
            for (int k = 0; k < 2; k++) begin
                a.d = o_d[k]; a.l = o_l[k]; a.u = o_u[k];
                chk("frame_err", 64'(ferr[k]), 64'(merr));
                if (o_v[k]) begin
                    if (was_stall[k]) chk("hold_stable", 64'(a), 64'(held[k]));
                    if (d_mready) begin
                        if (rd[k] >= expq.size()) begin
                            chk("extra_word", 64'(rd[k]), 64'(expq.size()));
                        end else begin
                            e = expq[rd[k]];
                            chk("tdata", 64'(a.d), 64'((k == 0) ? e.d0 : e.d1));
                            chk("tlast", 64'(a.l), 64'(e.l));
                            chk("tuser", 64'(a.u), 64'(e.u));
                            rd[k]++;
                            if (k == 0) lg0.push_back(a); else lg1.push_back(a);
                        end
                    end
                end
                was_stall[k] = o_v[k] & ~d_mready;
                held[k] = a;
            end
            if (d_tvalid && o_sr[0]) begin
                ch  = (pos >= N) ? 1 : 0;
                bin = pos % N;
                e.d0 = pwr(d_tdata, 0);
                e.d1 = pwr(d_tdata, 30);
                e.l  = (bin == N - 1) || d_tlast;
                e.u  = {d_tlast, 1'(ch), BW'(bin)};
                expq.push_back(e);
                if (d_tlast && pos != 2 * N - 1) merr = 1'b1;
                pos = d_tlast ? 0 : (pos + 1) % (2 * N);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        d_mready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
    end

    task automatic send(input logic [31:0] re, input logic [31:0] im, input logic last);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        d_tdata = {im, re};
        d_tvalid = 1'b1;
        d_tlast = last;
        while (!acc) begin
            @(negedge clk);
            acc = o_sr[0];
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 200) begin
                chk("send_timeout", 64'(n), 64'(0));
                break;
            end
        end
        d_tvalid = 1'b0;
        d_tlast = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rd[0] != expq.size() || rd[1] != expq.size()) && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain_count0", 64'(rd[0]), 64'(expq.size()));
        chk("drain_count1", 64'(rd[1]), 64'(expq.size()));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, lat;
        logic [31:0] sq [8];
        logic [31:0] re, im, t1, t2;
        sq = '{32'd0, 32'd1, 32'd4, 32'd9, 32'd0, 32'd1, 32'd4, 32'd9};
        reset = 1'b1;
        d_tdata = '0; d_tvalid = 1'b0; d_tlast = 1'b0; d_mready = 1'b1;
        #1;
        chk("rst_tvalid", 64'(o_v[0]), 64'(0));
        chk("rst_tdata",  64'(o_d[0]), 64'(0));
        chk("rst_tlast",  64'(o_l[0]), 64'(0));
        chk("rst_tuser",  64'(o_u[0]), 64'(0));
        chk("rst_ferr",   64'(ferr[0]), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // single word 3+4j: 25 after three cycles
        d_tdata = {32'd4, 32'd3}; d_tvalid = 1'b1;
        @(negedge clk);
        chk("single_accept", 64'(o_sr[0]), 64'(1));
        @(posedge clk); #1 d_tvalid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_v[0] && lat < 10);
        chk("latency", 64'(lat), 64'(3));
        chk("single_tdata", 64'(o_d[0]), 64'(25));
        chk("single_tuser", 64'(o_u[0]), 64'(0));
        drain();

        // two frames, re = bin
        do_reset();
        base = lg0.size();
        for (int i = 0; i < 8; i++) send(32'(i % 4), 32'd0, i == 7);
        drain();
        for (int i = 0; i < 8; i++) begin
            chk("frames_tdata", 64'(lg0[base + i].d), 64'(sq[i]));
            chk("frames_tlast", 64'(lg0[base + i].l), 64'(i == 3 || i == 7));
            chk("frames_tuser", 64'(lg0[base + i].u), 64'({(i == 7), (i >= 4), BW'(i % 4)}));
        end
        chk("frames_ferr", 64'(ferr[0]), 64'(0));

        // saturation and shift-30 boundaries
        do_reset();
        base = lg1.size();
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        send(32'h0000_8000, 32'd0, 1'b0);
        send(32'h8000_0000, 32'd0, 1'b0);
        send(32'h7FFF_FFFF, 32'd0, 1'b0);
        drain();
        chk("sat_both_s30", 64'(lg1[base].d), 64'h0000_0000_FFFF_FFFF);
        chk("sat_both_s0",  64'(lg0[base].d), 64'h0000_0000_FFFF_FFFF);
        chk("pow2_30_s30",  64'(lg1[base + 1].d), 64'd1);
        chk("pow2_62_s30",  64'(lg1[base + 2].d), 64'h0000_0000_FFFF_FFFF);
        chk("maxpos_s30",   64'(lg1[base + 3].d), 64'h0000_0000_FFFF_FFFC);

        // random backpressure, continuous input, 20 frames
        do_reset();
        stall_pct = 30;
        for (int i = 0; i < 20 * N; i++) begin
            t1 = $urandom; t2 = $urandom;
            re = t1[31] ? $urandom : {{17{t1[14]}}, t1[14:0]};
            im = t2[31] ? $urandom : {{17{t2[14]}}, t2[14:0]};
            send(re, im, i == 20 * N - 1);
        end
        // bubbles with backpressure
        for (int i = 0; i < 2 * N; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
            send($urandom, {{17{1'b0}}, 15'($urandom)}, i == 2 * N - 1);
        end
        drain();
        stall_pct = 0;
        drain();

        // tlast on left bin 1
        do_reset();
        base = lg0.size();
        send(32'd5, 32'd0, 1'b0);
        send(32'd6, 32'd0, 1'b1);
        chk("misalign_ferr_next", 64'(ferr[0]), 64'(1));
        send(32'd7, 32'd0, 1'b0);
        drain();
        chk("misalign_tlast", 64'(lg0[base + 1].l), 64'(1));
        chk("misalign_tuser", 64'(lg0[base + 1].u), 64'({1'b1, 1'b0, BW'(1)}));
        chk("resync_tuser",   64'(lg0[base + 2].u), 64'(0));
        chk("resync_tdata",   64'(lg0[base + 2].d), 64'd49);

        // asynchronous reset with two words in flight
        send(32'd1, 32'd1, 1'b0);
        send(32'd2, 32'd2, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_tvalid0", 64'(o_v[0]), 64'(0));
        chk("async_rst_ferr0",   64'(ferr[0]), 64'(0));
        chk("async_rst_tvalid1", 64'(o_v[1]), 64'(0));
        chk("async_rst_ferr1",   64'(ferr[1]), 64'(0));
        @(posedge clk); #1 reset = 1'b0;
        base = lg0.size();
        send(32'd9, 32'd9, 1'b0);
        drain();
        chk("post_rst_tuser", 64'(lg0[base].u), 64'(0));
        chk("post_rst_tdata", 64'(lg0[base].d), 64'd162);
        chk("post_rst_count", 64'(lg0.size() - base), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
